// File: rtl/wb_counter_ctrl_pkg.sv
// Shared definitions for the Wishbone counter sequencer: register map,
// CTRL/STATUS bit positions and the run-state encoding.
package wb_counter_ctrl_pkg;

  localparam logic [1:0] ADR_CTRL   = 2'd0;
  localparam logic [1:0] ADR_STEPS  = 2'd1;
  localparam logic [1:0] ADR_STATUS = 2'd2;
  localparam logic [1:0] ADR_COUNT  = 2'd3;

  localparam int CTRL_START    = 0;
  localparam int CTRL_STOP     = 1;
  localparam int CTRL_DIR      = 2;
  localparam int CTRL_PINGPONG = 3;
  localparam int CTRL_IRQ_EN   = 4;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_WRAP = 2;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

endpackage

// File: rtl/wb_counter_ctrl_if.sv
// Wishbone B4 classic bus bundle between the interconnect (master) and the
// counter sequencer (slave).
interface wb_counter_ctrl_if;

  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [3:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
    output wb_dat_o, wb_ack_o
  );

endinterface

// File: rtl/wb_counter_ctrl_reg_if.sv
// Wishbone slave front end: one-cycle ack, address decode into per-register
// write strobes, and a read mux registered into the ack cycle.
module wb_reg_if
  import wb_counter_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  wb_counter_ctrl_if.slave bus,
  input  logic [31:0]  i_ctrlRd,
  input  logic [31:0]  i_stepsRd,
  input  logic [31:0]  i_statusRd,
  input  logic [31:0]  i_countRd,
  output logic         o_ctrlWr,
  output logic         o_stepsWr,
  output logic         o_statusWr,
  output logic [31:0]  o_wrData
);

  logic        r_ack;
  logic [31:0] r_datO;
  logic        w_req;
  logic        w_wr;
  logic [1:0]  w_sel;
  logic [31:0] w_rdMux;
  logic        w_unusedAdr;

  // A request is only accepted while ack is low, so every access takes two cycles.
  assign w_req       = bus.wb_cyc_i & bus.wb_stb_i & ~r_ack;
  assign w_wr        = w_req & bus.wb_we_i;
  assign w_sel       = bus.wb_adr_i[3:2];
  assign w_unusedAdr = &{1'b0, bus.wb_adr_i[1:0]};

  assign o_ctrlWr   = w_wr & (w_sel == ADR_CTRL);
  assign o_stepsWr  = w_wr & (w_sel == ADR_STEPS);
  assign o_statusWr = w_wr & (w_sel == ADR_STATUS);
  assign o_wrData   = bus.wb_dat_i;

  always_comb begin
    w_rdMux = '0;
    case (w_sel)
      ADR_CTRL:   w_rdMux = i_ctrlRd;
      ADR_STEPS:  w_rdMux = i_stepsRd;
      ADR_STATUS: w_rdMux = i_statusRd;
      ADR_COUNT:  w_rdMux = i_countRd;
      default:    w_rdMux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack  <= 1'b0;
      r_datO <= '0;
    end else begin
      r_ack  <= w_req;
      r_datO <= (w_req & ~bus.wb_we_i) ? w_rdMux : '0;
    end
  end

  assign bus.wb_ack_o = r_ack;
  assign bus.wb_dat_o = r_datO;

endmodule

// File: rtl/wb_counter_ctrl.sv
// Counter sequencer: software programs direction, mode and a step budget, and
// this block drives the counter's enable/direction and reports BUSY/DONE/WRAP.
module wb_counter_ctrl
  import wb_counter_ctrl_pkg::*;
#(
  parameter int CNT_W  = 4,
  parameter int STEP_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  wb_counter_ctrl_if.slave bus,
  output logic             cnt_en,
  output logic             cnt_up_down,
  input  logic [CNT_W-1:0] cnt_count,
  output logic             irq
);

  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);

  logic              r_dir;
  logic              r_pingpong;
  logic              r_irqEn;
  logic [STEP_W-1:0] r_steps;
  logic              r_done;
  logic              r_wrap;
  logic              r_irq;
  logic [STEP_W-1:0] r_stepsLeft;
  logic              r_dirQ;
  logic              r_ppQ;
  logic              r_cntEn;
  state_t            r_state;

  logic              w_ctrlWr;
  logic              w_stepsWr;
  logic              w_statusWr;
  logic [31:0]       w_wrData;
  logic              w_start;
  logic              w_stop;
  logic              w_lastStep;
  state_t            w_stateNext;
  logic              w_load;
  logic              w_cntEnNext;
  logic              w_doneSet;
  logic              w_upDown;
  logic              w_wrapEvent;
  logic              w_unusedWrData;

  wb_reg_if u_regIf (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .i_ctrlRd   (32'({r_irqEn, r_pingpong, r_dir, 2'b00})),
    .i_stepsRd  (32'(r_steps)),
    .i_statusRd (32'({r_wrap, r_done, (r_state == S_RUN)})),
    .i_countRd  (32'(cnt_count)),
    .o_ctrlWr   (w_ctrlWr),
    .o_stepsWr  (w_stepsWr),
    .o_statusWr (w_statusWr),
    .o_wrData   (w_wrData)
  );

  assign w_unusedWrData = &{1'b0, w_wrData[31:STEP_W]};
  assign w_start        = w_ctrlWr & w_wrData[CTRL_START];
  assign w_stop         = w_ctrlWr & w_wrData[CTRL_STOP];
  // A zero budget loads steps_left with 0, which never decrements and never hits 1.
  assign w_lastStep     = r_cntEn & (r_stepsLeft == STEP_ONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE: if (w_start && !w_stop) w_stateNext = S_RUN;
      S_RUN: begin
        if (w_stop)          w_stateNext = S_IDLE;
        else if (w_start)    w_stateNext = S_RUN;
        else if (w_lastStep) w_stateNext = S_IDLE;
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  always_comb begin
    w_load      = w_start & ~w_stop;
    w_cntEnNext = (w_stateNext == S_RUN);
    w_doneSet   = (r_state == S_RUN) & ~w_stop & ~w_start & w_lastStep;
  end

  // Ping-pong reflects at the limits using the live count, so the counter never wraps.
  always_comb begin
    w_upDown = r_dirQ;
    if (r_ppQ) begin
      if (cnt_count == CNT_MAX)   w_upDown = 1'b0;
      else if (cnt_count == '0)   w_upDown = 1'b1;
    end
  end

  assign w_wrapEvent = r_cntEn & ~r_ppQ &
                       ((w_upDown & (cnt_count == CNT_MAX)) | (~w_upDown & (cnt_count == '0)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dir      <= 1'b0;
      r_pingpong <= 1'b0;
      r_irqEn    <= 1'b0;
      r_steps    <= '0;
    end else begin
      if (w_ctrlWr) begin
        r_dir      <= w_wrData[CTRL_DIR];
        r_pingpong <= w_wrData[CTRL_PINGPONG];
        r_irqEn    <= w_wrData[CTRL_IRQ_EN];
      end
      if (w_stepsWr) r_steps <= w_wrData[STEP_W-1:0];
    end
  end

  // Run datapath; a START takes DIR and PINGPONG from the same write that carries it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cntEn     <= 1'b0;
      r_stepsLeft <= '0;
      r_dirQ      <= 1'b1;
      r_ppQ       <= 1'b0;
    end else begin
      r_cntEn <= w_cntEnNext;
      if (w_load) begin
        r_stepsLeft <= r_steps;
        r_dirQ      <= w_wrData[CTRL_DIR];
        r_ppQ       <= w_wrData[CTRL_PINGPONG];
      end else if (r_cntEn) begin
        r_dirQ <= w_upDown;
        if (r_stepsLeft != '0) r_stepsLeft <= r_stepsLeft - STEP_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done <= 1'b0;
      r_wrap <= 1'b0;
      r_irq  <= 1'b0;
    end else begin
      r_done <= w_doneSet   | (r_done & ~(w_statusWr & w_wrData[STAT_DONE]));
      r_wrap <= w_wrapEvent | (r_wrap & ~(w_statusWr & w_wrData[STAT_WRAP]));
      r_irq  <= r_irqEn & (r_done | r_wrap);
    end
  end

  assign cnt_en      = r_cntEn;
  assign cnt_up_down = w_upDown;
  assign irq         = r_irq;

endmodule
